// File: rtl/npu_pkg.sv
// Shared definitions for the NPU layer sequencer: state encoding, RAM
// address widths and default phase lengths.
package npu_pkg;

  localparam int unsigned IMG_AW = 10;   // image RAM address width
  localparam int unsigned W_AW   = 15;   // conv / dense / bias RAM address width

  localparam int unsigned CONV_LEN_DEF   = 36;
  localparam int unsigned IMG_LEN_DEF    = 196;
  localparam int unsigned DENSE_ROWS_DEF = 10;
  localparam int unsigned ROW_LEN_DEF    = 169;
  localparam int unsigned DRAIN_CYC_DEF  = 8;

  // Encoding is visible to software through the status register.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_IMG   = 3'd2,
    ST_DENSE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/npu_layer_sequencer_if.sv
// Host/memory-side bundle of the layer sequencer.
//   master : host control decode + RAM read path (drives start/abort/stall)
//   slave  : the sequencer (drives RAM addresses, enables and status)
interface npu_layer_sequencer_if;
  import npu_pkg::*;

  logic              start;
  logic              abort;
  logic              stall;
  logic [IMG_AW-1:0] image_ram_addr;
  logic [W_AW-1:0]   conv_ram_addr;
  logic [W_AW-1:0]   dense_ram_addr;
  logic [W_AW-1:0]   denseb_ram_addr;
  logic              en_config;
  logic              en_fsm;
  logic              busy;
  logic              done;
  logic [2:0]        state_o;

  modport master (
    output start, abort, stall,
    input  image_ram_addr, conv_ram_addr, dense_ram_addr, denseb_ram_addr,
    input  en_config, en_fsm, busy, done, state_o
  );

  modport slave (
    input  start, abort, stall,
    output image_ram_addr, conv_ram_addr, dense_ram_addr, denseb_ram_addr,
    output en_config, en_fsm, busy, done, state_o
  );

endinterface

// File: rtl/seq_addr_counter.sv
// Generic saturating up-counter used for each address stream and the drain
// timer. Counts on en_i until it reaches limit_i, then holds there until
// cleared.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : synchronous clear to 0 (wins over en_i)
//   en_i        : advance by one
//   limit_i     : final count value
//   cnt_o       : registered count
//   last_c_o    : combinational, cnt_o == limit_i
module seq_addr_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         last_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_c_o = (cnt_q == limit_i);
  assign cnt_o    = cnt_q;

  // Next count: never passes the limit, so no wrap within a pass.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_c_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/npu_layer_sequencer.sv
// Sequences one inference pass: streams conv weights (CFG), image words (IMG)
// and dense weights/biases (DENSE), waits for the NPU pipeline to drain, then
// pulses done. Enables are the issue strobes delayed one cycle so they line up
// with synchronous RAM read data.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of npu_layer_sequencer_if (start/abort/stall in;
//                RAM addresses, en_config/en_fsm, busy/done/state_o out)
module npu_layer_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned CONV_LEN   = CONV_LEN_DEF,
  parameter int unsigned IMG_LEN    = IMG_LEN_DEF,
  parameter int unsigned DENSE_ROWS = DENSE_ROWS_DEF,
  parameter int unsigned ROW_LEN    = ROW_LEN_DEF,
  parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEF
) (
  input logic                  clk,
  input logic                  reset,
  npu_layer_sequencer_if.slave bus
);

  localparam int unsigned COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  seq_state_t        state_q, state_d;
  logic              issue_cfg_c, issue_img_c, issue_dense_c, drain_en_c, clr_c;
  logic              conv_last_c, img_last_c, dense_last_c, row_last_c, drain_last_c;
  logic              col_last_c, row_adv_c;
  logic [COL_W-1:0]  col_q, col_d;
  logic [IMG_AW-1:0] img_cnt;
  logic [W_AW-1:0]   conv_cnt, dense_cnt, row_cnt;
  logic [DRN_W-1:0]  drain_cnt_unused;
  logic              en_config_q, en_fsm_q, done_q, busy_q;
  logic              done_d, busy_d;

  // Issue strobes: a read address is presented this cycle and will advance.
  assign issue_cfg_c   = (state_q == ST_CFG)   && !bus.stall && !bus.abort;
  assign issue_img_c   = (state_q == ST_IMG)   && !bus.stall && !bus.abort;
  assign issue_dense_c = (state_q == ST_DENSE) && !bus.stall && !bus.abort;
  assign drain_en_c    = (state_q == ST_DRAIN) && !bus.abort;

  // All counters return to 0 as the FSM enters IDLE (end of pass or abort).
  assign clr_c = (state_d == ST_IDLE);

  // Next-state logic; abort dominates start and stall.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (bus.start)                   state_d = ST_CFG;
        ST_CFG:   if (issue_cfg_c && conv_last_c)  state_d = ST_IMG;
        ST_IMG:   if (issue_img_c && img_last_c)   state_d = ST_DENSE;
        ST_DENSE: if (issue_dense_c && dense_last_c) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_last_c)                state_d = ST_DONE;
        ST_DONE:                                   state_d = ST_IDLE;
        default:                                   state_d = ST_IDLE;
      endcase
    end
  end

  // done follows the DONE state by one cycle, like the enables follow issue;
  // busy covers every non-IDLE state plus the done cycle itself.
  assign done_d = (state_q == ST_DONE) && !bus.abort;
  assign busy_d = (state_d != ST_IDLE) || done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      en_config_q <= 1'b0;
      en_fsm_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_config_q <= issue_cfg_c;
      en_fsm_q    <= issue_img_c | issue_dense_c;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Position within the current dense row; the bias address steps as it wraps.
  assign col_last_c = (col_q == COL_W'(ROW_LEN - 1));
  assign row_adv_c  = issue_dense_c && col_last_c && !row_last_c;

  always_comb begin
    col_d = col_q;
    if (clr_c) begin
      col_d = '0;
    end else if (issue_dense_c) begin
      col_d = col_last_c ? '0 : col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) col_q <= '0;
    else        col_q <= col_d;
  end

  seq_addr_counter #(.W(W_AW)) u_conv_cnt (
    .clk(clk), .rst_n(reset), .clr_i(clr_c), .en_i(issue_cfg_c),
    .limit_i(W_AW'(CONV_LEN - 1)), .cnt_o(conv_cnt), .last_c_o(conv_last_c)
  );

  seq_addr_counter #(.W(IMG_AW)) u_img_cnt (
    .clk(clk), .rst_n(reset), .clr_i(clr_c), .en_i(issue_img_c),
    .limit_i(IMG_AW'(IMG_LEN - 1)), .cnt_o(img_cnt), .last_c_o(img_last_c)
  );

  seq_addr_counter #(.W(W_AW)) u_dense_cnt (
    .clk(clk), .rst_n(reset), .clr_i(clr_c), .en_i(issue_dense_c),
    .limit_i(W_AW'(DENSE_ROWS * ROW_LEN - 1)), .cnt_o(dense_cnt),
    .last_c_o(dense_last_c)
  );

  seq_addr_counter #(.W(W_AW)) u_row_cnt (
    .clk(clk), .rst_n(reset), .clr_i(clr_c), .en_i(row_adv_c),
    .limit_i(W_AW'(DENSE_ROWS - 1)), .cnt_o(row_cnt), .last_c_o(row_last_c)
  );

  seq_addr_counter #(.W(DRN_W)) u_drain_cnt (
    .clk(clk), .rst_n(reset), .clr_i(clr_c), .en_i(drain_en_c),
    .limit_i(DRN_W'(DRAIN_CYC - 1)), .cnt_o(drain_cnt_unused),
    .last_c_o(drain_last_c)
  );

  assign bus.image_ram_addr  = img_cnt;
  assign bus.conv_ram_addr   = conv_cnt;
  assign bus.dense_ram_addr  = dense_cnt;
  assign bus.denseb_ram_addr = row_cnt;
  assign bus.en_config       = en_config_q;
  assign bus.en_fsm          = en_fsm_q;
  assign bus.done            = done_q;
  assign bus.busy            = busy_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed bench for npu_layer_sequencer: one default-size instance and one
// small instance (CONV_LEN=2, IMG_LEN=3, DENSE_ROWS=2, ROW_LEN=3).
module tb_npu_layer_sequencer;
  import npu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  npu_layer_sequencer_if b ();
  npu_layer_sequencer_if s ();

  npu_layer_sequencer u_big (.clk(clk), .reset(reset), .bus(b));

  npu_layer_sequencer #(
    .CONV_LEN(2), .IMG_LEN(3), .DENSE_ROWS(2), .ROW_LEN(3), .DRAIN_CYC(8)
  ) u_small (.clk(clk), .reset(reset), .bus(s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one pass on the default instance and reports its timing, relative to
  // the cycle in which start is presented (cycle 0). Optionally stalls for 3
  // cycles at image address stall_at, or re-pulses start at cycle 10.
  task automatic run_pass(input int stall_at, input bit restart,
                          output int n_cfg, output int first_cfg,
                          output int n_fsm, output int first_fsm,
                          output int n_done, output int done_cyc,
                          output int busy_fall, output int serr);
    int kc, kf, d, stall_left, stall_t;
    logic [IMG_AW-1:0] p_img;
    logic [W_AW-1:0]   p_conv, p_dense, p_db;
    n_cfg = 0; first_cfg = -1; n_fsm = 0; first_fsm = -1;
    n_done = 0; done_cyc = -1; busy_fall = -1; serr = 0;
    kc = 0; kf = 0; stall_left = 0; stall_t = -1;
    p_img = b.image_ram_addr; p_conv = b.conv_ram_addr;
    p_dense = b.dense_ram_addr; p_db = b.denseb_ram_addr;
    b.start = 1'b1;
    for (int cyc = 1; cyc <= 2300; cyc++) begin
      step();
      if (cyc == 1) b.start = 1'b0;
      if (restart && cyc == 10) b.start = 1'b1;
      if (restart && cyc == 11) b.start = 1'b0;
      // Enabled data belongs to the address presented one cycle earlier.
      if (b.en_config) begin
        if (first_cfg < 0) first_cfg = cyc;
        if (p_conv !== W_AW'(kc)) serr++;
        kc++; n_cfg++;
      end
      if (b.en_fsm) begin
        if (first_fsm < 0) first_fsm = cyc;
        if (kf < int'(IMG_LEN_DEF)) begin
          if (p_img !== IMG_AW'(kf)) serr++;
        end else begin
          d = kf - int'(IMG_LEN_DEF);
          if (p_dense !== W_AW'(d) || p_db !== W_AW'(d / int'(ROW_LEN_DEF))) serr++;
        end
        kf++; n_fsm++;
      end
      if (b.done) begin n_done++; done_cyc = cyc; end
      if (busy_fall < 0 && n_done > 0 && !b.busy) busy_fall = cyc;
      if (stall_t >= 0) begin
        if (cyc > stall_t && cyc <= stall_t + 3) begin
          check("stall_addr_hold", 32'(b.image_ram_addr), 32'(stall_at));
          check("stall_en_fsm_low", 32'(b.en_fsm), 32'd0);
        end
        if (cyc == stall_t + 4) begin
          check("stall_addr_resume", 32'(b.image_ram_addr), 32'(stall_at + 1));
          check("stall_en_fsm_resume", 32'(b.en_fsm), 32'd1);
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) b.stall = 1'b0;
      end
      if (stall_at >= 0 && stall_t < 0 && b.state_o == 3'd2 &&
          b.image_ram_addr == IMG_AW'(stall_at)) begin
        b.stall = 1'b1; stall_left = 3; stall_t = cyc;
      end
      p_img = b.image_ram_addr; p_conv = b.conv_ram_addr;
      p_dense = b.dense_ram_addr; p_db = b.denseb_ram_addr;
      if (busy_fall >= 0) break;
    end
  endtask

  int n_cfg, first_cfg, n_fsm, first_fsm, n_done, done_cyc, busy_fall, serr;
  int cnt, k, sd_n, sd_cyc;
  int q_conv[$], q_img[$], q_dense[$], q_db[$];
  int exp_conv [2] = '{0, 1};
  int exp_img  [3] = '{0, 1, 2};
  int exp_dense[6] = '{0, 1, 2, 3, 4, 5};
  int exp_db   [6] = '{0, 0, 0, 1, 1, 1};
  logic [IMG_AW-1:0] ps_img;
  logic [W_AW-1:0]   ps_conv, ps_dense, ps_db;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b.start = 0; b.abort = 0; b.stall = 0;
    s.start = 0; s.abort = 0; s.stall = 0;
    step(); step();
    check("rst_state", 32'(b.state_o), 32'd0);
    check("rst_addr_sum", 32'(b.image_ram_addr) + 32'(b.conv_ram_addr) +
          32'(b.dense_ram_addr) + 32'(b.denseb_ram_addr), 32'd0);
    check("rst_en", {30'd0, b.en_config, b.en_fsm}, 32'd0);
    check("rst_busy_done", {30'd0, b.busy, b.done}, 32'd0);
    reset = 1'b1;
    step();

    // Plain full pass with default lengths.
    run_pass(-1, 1'b0, n_cfg, first_cfg, n_fsm, first_fsm, n_done, done_cyc, busy_fall, serr);
    check("p1_cfg_first", 32'(first_cfg), 32'd2);
    check("p1_cfg_count", 32'(n_cfg), 32'd36);
    check("p1_fsm_first", 32'(first_fsm), 32'd38);
    check("p1_fsm_count", 32'(n_fsm), 32'd1886);
    check("p1_done_count", 32'(n_done), 32'd1);
    check("p1_done_cycle", 32'(done_cyc), 32'd1932);
    check("p1_busy_fall", 32'(busy_fall), 32'd1933);
    check("p1_stream", 32'(serr), 32'd0);
    check("p1_idle_addr", 32'(b.dense_ram_addr) + 32'(b.denseb_ram_addr) +
          32'(b.conv_ram_addr) + 32'(b.image_ram_addr), 32'd0);

    // Small instance: exact address streams.
    k = 0; sd_n = 0; sd_cyc = -1;
    ps_img = s.image_ram_addr; ps_conv = s.conv_ram_addr;
    ps_dense = s.dense_ram_addr; ps_db = s.denseb_ram_addr;
    s.start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (cyc == 1) s.start = 1'b0;
      if (s.en_config) q_conv.push_back(int'(ps_conv));
      if (s.en_fsm) begin
        if (k < 3) q_img.push_back(int'(ps_img));
        else begin q_dense.push_back(int'(ps_dense)); q_db.push_back(int'(ps_db)); end
        k++;
      end
      if (s.done) begin sd_n++; sd_cyc = cyc; end
      ps_img = s.image_ram_addr; ps_conv = s.conv_ram_addr;
      ps_dense = s.dense_ram_addr; ps_db = s.denseb_ram_addr;
    end
    check("s_conv_len", 32'(q_conv.size()), 32'd2);
    check("s_img_len", 32'(q_img.size()), 32'd3);
    check("s_dense_len", 32'(q_dense.size()), 32'd6);
    if (q_conv.size() == 2) for (int i = 0; i < 2; i++) check("s_conv", 32'(q_conv[i]), 32'(exp_conv[i]));
    if (q_img.size() == 3) for (int i = 0; i < 3; i++) check("s_img", 32'(q_img[i]), 32'(exp_img[i]));
    if (q_dense.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("s_dense", 32'(q_dense[i]), 32'(exp_dense[i]));
        check("s_denseb", 32'(q_db[i]), 32'(exp_db[i]));
      end
    end
    check("s_done_count", 32'(sd_n), 32'd1);
    check("s_done_cycle", 32'(sd_cyc), 32'd21);

    // Second start during CFG is ignored.
    run_pass(-1, 1'b1, n_cfg, first_cfg, n_fsm, first_fsm, n_done, done_cyc, busy_fall, serr);
    check("rs_done_count", 32'(n_done), 32'd1);
    check("rs_done_cycle", 32'(done_cyc), 32'd1932);
    check("rs_stream", 32'(serr), 32'd0);

    // Three stall cycles at image address 5.
    run_pass(5, 1'b0, n_cfg, first_cfg, n_fsm, first_fsm, n_done, done_cyc, busy_fall, serr);
    check("st_fsm_count", 32'(n_fsm), 32'd1886);
    check("st_done_cycle", 32'(done_cyc), 32'd1935);
    check("st_stream", 32'(serr), 32'd0);

    // Reset asserted mid-DENSE.
    b.start = 1'b1; step(); b.start = 1'b0;
    for (int i = 0; i < 400 && b.state_o != 3'd3; i++) step();
    check("mr_reach_dense", 32'(b.state_o), 32'd3);
    step(); step(); step();
    #1 reset = 1'b0;
    #1;
    check("mr_state", 32'(b.state_o), 32'd0);
    check("mr_addr_sum", 32'(b.image_ram_addr) + 32'(b.conv_ram_addr) +
          32'(b.dense_ram_addr) + 32'(b.denseb_ram_addr), 32'd0);
    check("mr_en_fsm", 32'(b.en_fsm), 32'd0);
    step(); step();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (b.done || b.busy) cnt++; end
    check("mr_no_done", 32'(cnt), 32'd0);

    // Abort during IMG at address 10.
    b.start = 1'b1; step(); b.start = 1'b0;
    for (int i = 0; i < 300 && !(b.state_o == 3'd2 && b.image_ram_addr == IMG_AW'(10)); i++) step();
    check("ab_reach_img10", 32'(b.image_ram_addr), 32'd10);
    b.abort = 1'b1; step(); b.abort = 1'b0;
    check("ab_state", 32'(b.state_o), 32'd0);
    check("ab_addr_sum", 32'(b.image_ram_addr) + 32'(b.conv_ram_addr) +
          32'(b.dense_ram_addr) + 32'(b.denseb_ram_addr), 32'd0);
    check("ab_en_fsm", 32'(b.en_fsm), 32'd0);
    check("ab_busy", 32'(b.busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (b.done) cnt++; end
    check("ab_no_done", 32'(cnt), 32'd0);
    run_pass(-1, 1'b0, n_cfg, first_cfg, n_fsm, first_fsm, n_done, done_cyc, busy_fall, serr);
    check("ab_next_fsm_count", 32'(n_fsm), 32'd1886);
    check("ab_next_done_cycle", 32'(done_cyc), 32'd1932);
    check("ab_next_stream", 32'(serr), 32'd0);

    // start together with abort in IDLE stays in IDLE.
    b.start = 1'b1; b.abort = 1'b1; step(); b.start = 1'b0; b.abort = 1'b0;
    check("sa_state", 32'(b.state_o), 32'd0);
    check("sa_busy", 32'(b.busy), 32'd0);
    step();
    check("sa_state_later", 32'(b.state_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/npu_layer_sequencer.md
Name: npu_layer_sequencer

Overview:
- Controller that sequences one inference pass through the NPU memory subsystem.
- Generates read addresses for the image, conv-weight, dense-weight and dense-bias RAM ports, and drives EN_CONFIG/EN_FSM aligned to RAM read data.
- Sits between the host control-register decode (start/abort) and the memory read path / npu_top. Replaces ad-hoc enable generation inside the read module.

Parameters:
- IMG_AW, 10, image RAM address width
- W_AW, 15, conv/dense/bias RAM address width
- CONV_LEN, 36, conv-weight words streamed in CFG phase
- IMG_LEN, 196, image words per bank streamed in IMG phase
- DENSE_ROWS, 10, dense output neurons (one bias word each)
- ROW_LEN, 169, dense-weight words per row
- DRAIN_CYC, 8, cycles waited after last read for the NPU pipeline to empty

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from control-register decode; begins a pass
- abort  in  1  synchronous abort; returns to IDLE
- stall  in  1  NPU back-pressure; freezes address counters
- image_ram_addr  out  IMG_AW  image RAM read address (all 4 banks)
- conv_ram_addr  out  W_AW  conv RAM read address
- dense_ram_addr  out  W_AW  dense RAM read address
- denseb_ram_addr  out  W_AW  dense-bias RAM read address
- en_config  out  1  NPU config enable, aligned to conv read data
- en_fsm  out  1  NPU run enable, aligned to image/dense read data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of pass
- state_o  out  3  current state encoding, for debug/status register

Behaviour:
- Reset (reset=0, async): state=IDLE; all addresses 0; en_config, en_fsm, busy, done = 0.
- States: IDLE, CFG, IMG, DENSE, DRAIN, DONE.
- IDLE: start=1 and abort=0 -> CFG next cycle. Addresses held at 0.
- CFG: conv_ram_addr counts 0..CONV_LEN-1, one per non-stalled cycle. After the cycle issuing CONV_LEN-1 -> IMG.
- IMG: image_ram_addr counts 0..IMG_LEN-1 -> DENSE.
- DENSE: dense_ram_addr counts 0..DENSE_ROWS*ROW_LEN-1 continuously. denseb_ram_addr = current row index, incrementing on the cycle dense_ram_addr crosses a row boundary. After the last word -> DRAIN.
- DRAIN: counts DRAIN_CYC cycles (stall ignored) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. All addresses clear to 0 on entry to IDLE.
- Read latency: RAM data is valid one cycle after its address. Internal issue strobes are registered once:
  - en_config = issued-in-CFG delayed 1 cycle.
  - en_fsm = issued-in-IMG-or-DENSE delayed 1 cycle.
  - Consequently, the enables stay high for the one cycle after the phase ends.
- Stall=1: address counters and phase-completion hold. The issue strobe is 0 that cycle, so the matching enable is 0 in the following cycle. No address is skipped or repeated in the enabled stream.
- Abort=1 in any state: next state IDLE; enables drop next cycle; done not pulsed. Abort has priority over start and stall.
- Start while busy is ignored.
- Counter widths: the dense counter must hold DENSE_ROWS*ROW_LEN-1 within W_AW bits (1689 with defaults). No wrap occurs within a pass; counters never exceed their limit.
- state_o encoding: IDLE=0, CFG=1, IMG=2, DENSE=3, DRAIN=4, DONE=5.

Decomposition:
- Shared package npu_pkg holds:
  - state enum seq_state_t (encoding above)
  - RAM address width constants (IMG_AW, W_AW)
  - default phase lengths
- One sub-module: seq_addr_counter, a generic up-counter with clear, enable, limit and "last" flag. It is instantiated once per address stream and once for DRAIN.

Test Plan:
- Reset mid-DENSE (reset low 2 cycles) -> state_o=0, all addresses 0, en_fsm=0 immediately; no done pulse afterwards.
- start with defaults, no stall:
  - en_config high for exactly 36 cycles, starting 2 cycles after start.
  - en_fsm high for 196+1690 contiguous cycles.
  - done pulses once at cycle 2+36+196+1690+8.
  - busy drops the cycle after done.
- Small params (CONV_LEN=2, IMG_LEN=3, DENSE_ROWS=2, ROW_LEN=3) -> addresses seen:
  - conv 0,1
  - image 0,1,2
  - dense 0..5 with denseb 0,0,0,1,1,1
  - done after DRAIN_CYC.
- Stall asserted 3 cycles at image_ram_addr=5:
  - address holds at 5 for 3 cycles.
  - en_fsm low for 3 cycles, delayed by 1.
  - total enabled image words still 196.
- abort during IMG at addr 10 -> IDLE next cycle, no done, addresses 0.
  - Subsequent start runs a full correct pass.
- start pulsed again during CFG -> ignored; exactly one done for the pass.
- start and abort in the same cycle in IDLE -> remains IDLE.
